// File: rtl/sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sched_pkg                                                     |
// | Brief    : Shared constants and the wrap-around pick for fire_scheduler  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package sched_pkg;

    localparam logic [1:0]  c_ST_IDLE    = 2'd0;
    localparam logic [1:0]  c_ST_RUN     = 2'd1;
    localparam logic [1:0]  c_ST_HALT_DL = 2'd2;
    localparam logic [1:0]  c_ST_HALT_HZ = 2'd3;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;

    // One-hot of the first set bit of vec at or above start, wrapping at n.
    // start must already be below n.
    function automatic logic [31:0] first_from(
        input logic [31:0] vec,
        input logic [4:0]  start,
        input int unsigned n
    );
        logic [31:0] pick;
        logic        found;
        int unsigned idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < 32; k++) begin
            idx = {27'd0, start} + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((k < n) && !found && vec[idx[4:0]]) begin
                pick[idx[4:0]] = 1'b1;
                found          = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fire_scheduler_lfsr16.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lfsr16                                                        |
// | Brief    : 16-bit right-shifting Galois LFSR with load-on-reset seed     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module lfsr16
    import sched_pkg::*;
(
    input  logic        CK,
    input  logic        RS,
    input  logic        adv,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    logic [15:0] r_value;
    logic [15:0] w_next;

    always_comb begin
        w_next = {1'b0, r_value[15:1]};
        if (r_value[0]) begin
            w_next = w_next ^ LFSR_TAPS;
        end
    end

    always_ff @(posedge CK) begin
        if (RS) begin
            r_value <= seed;
        end else if (adv) begin
            r_value <= w_next;
        end
    end

    assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/fire_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fire_scheduler                                                |
// | Brief    : Picks which excited gates fire each cycle; flags deadlock and |
// |            semi-modularity hazards and halts on either                   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module fire_scheduler
    import sched_pkg::*;
#(
    parameter int          N         = 8,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          DL_CYCLES = 4
) (
    input  logic                 CK,
    input  logic                 RS,
    input  logic                 GO,
    input  logic                 MODE,
    input  logic [N-1:0]         Q,
    input  logic [N-1:0]         PRECAP,
    output logic [N-1:0]         ENA,
    output logic [N-1:0]         EXCITED,
    output logic                 DEADLOCK,
    output logic                 HAZARD,
    output logic [$clog2(N)-1:0] HAZARD_IDX,
    output logic [15:0]          FIRE_COUNT
);

    localparam int              c_IW     = $clog2(N);
    localparam int              c_DW     = $clog2(DL_CYCLES + 1);
    localparam int unsigned     c_N32    = N;
    localparam logic [c_DW-1:0] c_DL_MAX = c_DW'(DL_CYCLES);

    logic [1:0]      r_state;
    logic [N-1:0]    r_exc_prev;
    logic [N-1:0]    r_ena_prev;
    logic            r_pv;
    logic [c_DW-1:0] r_dl;
    logic            r_deadlock;
    logic            r_hazard;
    logic [c_IW-1:0] r_hidx;
    logic [15:0]     r_fire_count;

    logic            w_run;
    logic [15:0]     w_lfsr;
    logic [N-1:0]    w_exc;
    logic [31:0]     w_exc32;
    logic [31:0]     w_pick32;
    logic [4:0]      w_start;
    logic [N-1:0]    w_ena;
    logic [N-1:0]    w_h;
    logic            w_hz;
    logic [c_IW-1:0] w_hidx;
    logic [c_DW-1:0] w_dl_next;
    logic            w_dl_hit;
    logic            w_unused_lfsr;

    assign w_run         = (r_state == c_ST_RUN);
    assign w_exc         = PRECAP ^ Q;
    assign w_unused_lfsr = |w_lfsr[15:5];

    lfsr16 u_lfsr (
        .CK    (CK),
        .RS    (RS),
        .adv   (w_run),
        .seed  (SEED),
        .value (w_lfsr)
    );

    generate
        if (N < 32) begin : g_ext
            logic w_unused_pick;
            assign w_exc32       = {{(32 - N){1'b0}}, w_exc};
            assign w_unused_pick = |w_pick32[31:N];
        end else begin : g_full
            assign w_exc32 = w_exc;
        end
    endgenerate

    always_comb begin
        w_start  = 5'({27'd0, w_lfsr[4:0]} % c_N32);
        w_pick32 = first_from(w_exc32, w_start, c_N32);
    end

    // Reset gates ENA in the same cycle so no gate captures while RS is high.
    always_comb begin
        w_ena = '0;
        if (!RS && w_run) begin
            w_ena = MODE ? w_exc : w_pick32[N-1:0];
        end
    end

    // A gate that was excited, left unfired, and is no longer excited was
    // disabled by someone else's transition.
    assign w_h  = r_exc_prev & ~r_ena_prev & ~w_exc;
    assign w_hz = w_run && r_pv && (w_h != '0);

    always_comb begin
        w_hidx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_h[i]) begin
                w_hidx = c_IW'(i);
            end
        end
    end

    always_comb begin
        w_dl_next = '0;
        if (w_exc == '0) begin
            w_dl_next = (r_dl == c_DL_MAX) ? r_dl : r_dl + 1'b1;
        end
    end

    assign w_dl_hit = w_run && (w_dl_next == c_DL_MAX);

    always_ff @(posedge CK) begin
        if (RS) begin
            r_state      <= c_ST_IDLE;
            r_exc_prev   <= '0;
            r_ena_prev   <= '0;
            r_pv         <= 1'b0;
            r_dl         <= '0;
            r_deadlock   <= 1'b0;
            r_hazard     <= 1'b0;
            r_hidx       <= '0;
            r_fire_count <= '0;
        end else begin
            if ((w_ena != '0) && (r_fire_count != 16'hFFFF)) begin
                r_fire_count <= r_fire_count + 16'd1;
            end
            case (r_state)
                c_ST_IDLE: begin
                    r_pv <= 1'b0;
                    r_dl <= '0;
                    if (GO) begin
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    r_pv       <= 1'b1;
                    r_exc_prev <= w_exc;
                    r_ena_prev <= w_ena;
                    r_dl       <= w_dl_next;
                    if (w_hz) begin
                        r_hazard <= 1'b1;
                        r_hidx   <= w_hidx;
                        r_state  <= c_ST_HALT_HZ;
                    end else if (w_dl_hit) begin
                        r_deadlock <= 1'b1;
                        r_state    <= c_ST_HALT_DL;
                    end else if (!GO) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign ENA        = w_ena;
    assign EXCITED    = w_exc;
    assign DEADLOCK   = r_deadlock;
    assign HAZARD     = r_hazard;
    assign HAZARD_IDX = r_hidx;
    assign FIRE_COUNT = r_fire_count;

endmodule
`default_nettype wire
